mips_mc_controller: RTL
=======================

MIPS_MC_CONTROLLER -- requirements
Module: MIPS_MC_Controller

Interface
REQ-001 SHALL have parameter FETCH_TIMEOUT, default 255: max cycles a memory request may wait for mem_ready before mem_fault.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port opcode  input  opcode_t  opcode field of instruction register.
REQ-005 SHALL have port funct  input  function_t  funct field of instruction register.
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_ready  input  1  memory completes current access this cycle.
REQ-008 SHALL have port mem_req  output  1  memory access requested.
REQ-009 SHALL have port ctrl  output  mc_control_t  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], pc_src[1:0].
REQ-010 SHALL have port alu_sel  output  alu_sel_t  ALU operation select.
REQ-011 SHALL have port state  output  mc_state_t  current state, for debug.
REQ-012 SHALL have port instr_done  output  1  one-cycle pulse on final cycle of each instruction.
REQ-013 SHALL have ports illegal_op and mem_fault  output  1 each  one-cycle error pulses.

Function
REQ-014 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-015 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op ADD, pc_src=00; ir_write and pc_en asserted only in the cycle mem_ready=1, then go to DECODE; else stay.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op ADD; next by opcode: LW/SW->MEMADR, R-type->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP; any other opcode->FETCH with illegal_op pulsed.
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10, alu_op ADD; LW->MEMRD, SW->MEMWR.
REQ-018 MEMRD: mem_req=1, iord=1; leave to MEMWB only when mem_ready=1. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; ->FETCH.
REQ-019 MEMWR: mem_req=1, iord=1, mem_write=1 held until mem_ready=1; ->FETCH.
REQ-020 EXEC: alu_src_a=1, alu_src_b=00, alu_op FUNCT; ->ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op SUB, pc_src=01, pc_en=zero; ->FETCH.
REQ-022 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op ADD; ->ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
REQ-023 JUMP: pc_src=10, pc_en=1; ->FETCH.
REQ-024 Zero-wait latency (rst low, mem_ready constant 1): LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3 cycles; each added wait cycle adds one cycle.
REQ-025 instr_done SHALL pulse in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and in MEMWR's completing cycle.
REQ-026 A 8-bit wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and increment each stalled cycle; on reaching FETCH_TIMEOUT, pulse mem_fault, drop mem_req, and go to FETCH with no write enable asserted.
REQ-027 All control outputs SHALL be Moore decodes of state except ir_write, pc_en (FETCH), mem_write-completion and BRANCH pc_en, which are gated by mem_ready/zero as stated.
REQ-028 Unused signals in each state SHALL be 0.

Reset
REQ-029 While rst=1 all outputs SHALL be 0 (mem_req, all ctrl enables, instr_done, error pulses); state register loads FETCH, wait counter 0.
REQ-030 rst asserted mid-instruction SHALL abort it with no reg_write/mem_write/pc_en in that cycle; first post-reset cycle is FETCH.

Structure
REQ-031 mc_state_t, mc_control_t, alu_op_t and opcode constants SHALL live in MIPS_SC_Definitions.pkg.
REQ-032 SHALL instantiate MIPS_ALU_Decoder for alu_op+funct->alu_sel; state register, next-state and output decode stay in this module.

Verification
REQ-033 LW (0x23), mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 with mem_to_reg=1 in cycle 5; instr_done in cycle 5.
REQ-034 R-type ADD (funct 0x20) -> EXEC alu_sel=ADD, ALUWB reg_dst=1, total 4 cycles.
REQ-035 BEQ with zero=1 then zero=0 -> pc_en=1 with pc_src=01 in BRANCH first case, pc_en=0 second.
REQ-036 SW with mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles, instr_done only on the mem_ready cycle, 7 total.
REQ-037 opcode 0x3F -> illegal_op pulse after DECODE, next state FETCH, no writes; mem_ready held 0 in FETCH -> mem_fault after 255 waits.
REQ-038 rst pulse during MEMRD -> all outputs 0 that cycle, FETCH next, no reg_write ever issued.

Source files
------------

// File: rtl/mips_mc_controller_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit:
// opcode and funct encodings, FSM state encoding, ALU op/select codes,
// and the packed datapath control word.
package mips_mc_controller_pkg;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] function_t;

  // Main opcodes understood by the controller
  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_J     = 6'h02;
  localparam opcode_t OP_BEQ   = 6'h04;
  localparam opcode_t OP_ADDI  = 6'h08;
  localparam opcode_t OP_LW    = 6'h23;
  localparam opcode_t OP_SW    = 6'h2B;

  // R-type funct codes understood by the ALU decoder
  localparam function_t FN_ADD = 6'h20;
  localparam function_t FN_SUB = 6'h22;
  localparam function_t FN_AND = 6'h24;
  localparam function_t FN_OR  = 6'h25;
  localparam function_t FN_SLT = 6'h2A;

  // FSM states; FETCH is zero so a cleared register means "start of instruction"
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } mc_state_t;

  // What the FSM asks of the ALU; FUNCT defers to the instruction's funct field
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'd0,
    ALU_OP_SUB   = 2'd1,
    ALU_OP_FUNCT = 2'd2
  } alu_op_t;

  // Operation select seen by the ALU datapath
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_sel_t;

  // Datapath control word; alu_src_b: 00 reg B, 01 const 4, 10 imm, 11 imm<<2
  // pc_src: 00 ALU result, 01 ALU out register (branch target), 10 jump target
  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
  } mc_control_t;

  // True for every opcode that has a defined execution path
  function automatic logic is_legal_opcode(input opcode_t op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_mc_controller_alu_decoder.sv
// Translates the FSM's coarse ALU request plus the R-type funct field
// into the concrete ALU operation select.
module mips_mc_controller_alu_decoder
  import mips_mc_controller_pkg::*;
(
  input  alu_op_t   alu_op,
  input  function_t funct,
  output alu_sel_t  alu_sel
);

  // Fixed ops pass straight through; FUNCT decodes R-type arithmetic,
  // unknown funct codes fall back to ADD so the ALU output stays defined.
  always_comb begin
    alu_sel = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_sel = ALU_ADD;
      ALU_OP_SUB: alu_sel = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_sel = ALU_ADD;
          FN_SUB:  alu_sel = ALU_SUB;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_SLT:  alu_sel = ALU_SLT;
          default: alu_sel = ALU_ADD;
        endcase
      end
      default: alu_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM. Sequences FETCH/DECODE and the per-class
// execute states, drives the datapath control word, and guards every
// memory wait with a timeout that aborts back to FETCH.
//
// Memory handshake: mem_req is held high for the whole access; the access
// completes in the cycle where mem_req and mem_ready are both high. Inputs
// may change freely while mem_req is high; nothing is latched until then.
module mips_mc_controller
  import mips_mc_controller_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  opcode_t     opcode,
  input  function_t   funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output mc_control_t ctrl,
  output alu_sel_t    alu_sel,
  output mc_state_t   state,
  output logic        instr_done,
  output logic        illegal_op,
  output logic        mem_fault
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(FETCH_TIMEOUT);

  mc_state_t  state_next;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_next;
  logic       waiting;
  logic       timeout;
  logic       entering_wait;
  alu_op_t    alu_op;
  alu_sel_t   dec_sel;

  // Memory-wait bookkeeping: which states stall on mem_ready and when they give up
  always_comb begin
    waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    timeout = waiting && (wait_cnt == TIMEOUT_CNT);
    entering_wait = (state_next != state) &&
                    ((state_next == S_FETCH) || (state_next == S_MEMRD) ||
                     (state_next == S_MEMWR));
  end

  // State register; reset always lands in FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Wait counter next value: cleared on entry to a waiting state or after a
  // timeout (FETCH re-entered from itself), otherwise counts stalled cycles
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (timeout || entering_wait) begin
      wait_cnt_next = 8'd0;
    end else if (waiting && !mem_ready) begin
      wait_cnt_next = wait_cnt + 8'd1;
    end
  end

  // Wait counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else begin
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (timeout)        state_next = S_FETCH;
        else if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (timeout)        state_next = S_FETCH;
        else if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: state_next = S_FETCH;
      S_MEMWR: begin
        if (timeout || mem_ready) state_next = S_FETCH;
      end
      S_EXEC:   state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Output decode: Moore per state, except FETCH/MEMWR completion gated by
  // mem_ready and BRANCH pc_en gated by zero. Reset and timeout force every
  // enable low so an aborted instruction leaves no architectural side effect.
  always_comb begin
    ctrl       = '0;
    mem_req    = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    mem_fault  = 1'b0;
    alu_op     = ALU_OP_ADD;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          if (timeout) begin
            mem_fault = 1'b1;
          end else begin
            mem_req        = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_en     = mem_ready;
          end
        end
        S_DECODE: begin
          ctrl.alu_src_b = 2'b11;
          illegal_op     = !is_legal_opcode(opcode);
        end
        S_MEMADR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          if (timeout) begin
            mem_fault = 1'b1;
          end else begin
            mem_req   = 1'b1;
            ctrl.iord = 1'b1;
          end
        end
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          instr_done      = 1'b1;
        end
        S_MEMWR: begin
          if (timeout) begin
            mem_fault = 1'b1;
          end else begin
            mem_req        = 1'b1;
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
            instr_done     = mem_ready;
          end
        end
        S_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          alu_op         = ALU_OP_FUNCT;
        end
        S_ALUWB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
          instr_done     = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.pc_src    = 2'b01;
          ctrl.pc_en     = zero;
          alu_op         = ALU_OP_SUB;
          instr_done     = 1'b1;
        end
        S_ADDIEX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'b10;
        end
        S_ADDIWB: begin
          ctrl.reg_write = 1'b1;
          instr_done     = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_src = 2'b10;
          ctrl.pc_en  = 1'b1;
          instr_done  = 1'b1;
        end
        default: begin
          ctrl = '0;
        end
      endcase
    end
  end

  mips_mc_controller_alu_decoder u_alu_decoder (
    .alu_op  (alu_op),
    .funct   (funct),
    .alu_sel (dec_sel)
  );

  // ALU select is held at the all-zero code while in reset
  always_comb begin
    alu_sel = rst ? ALU_AND : dec_sel;
  end

endmodule
